// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared defaults and index helpers for the sysArr output collector.
package sys_arr_pkg;
   localparam int WIDTH_HEIGHT = 4;
   localparam int SUM_BITS     = 16;

   function automatic int cnt_bits(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int col_lsb(input int col, input int bits);
      return col * bits;
   endfunction
endpackage

// File: rtl/sys_arr_sync_fifo.sv
// sys_arr_sync_fifo: power-of-two synchronous FIFO that accepts a push while full if a pop happens too.
module sys_arr_sync_fifo
   import sys_arr_pkg::*;
#(
   parameter int width = 64,
   parameter int depth = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [width-1:0]           din,
   output logic [width-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [cnt_bits(depth)-1:0] count
);
   localparam int AW = $clog2(depth);
   localparam int CW = cnt_bits(depth);

   logic [width-1:0] r_mem [depth];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign full   = r_count == CW'(depth);
   assign empty  = r_count == '0;
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);
   assign dout   = r_mem[r_rd];
   assign count  = r_count;

   // pointers are exactly log2(depth) bits, so wrap is free
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < depth; k++) r_mem[k] <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= din;
            r_wr        <= r_wr + 1'b1;
         end
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/sys_arr_deskew.sv
// sys_arr_deskew: re-aligns diagonal sysArr column outputs into rows and queues them
// behind a valid/ready handshake, with sticky skew and overflow flags.
module sys_arr_deskew
   import sys_arr_pkg::*;
#(
   parameter int width_height = WIDTH_HEIGHT,
   parameter int fifo_depth   = 4,
   parameter int sum_bits     = SUM_BITS
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic [sum_bits*width_height-1:0]     maccin,
   input  logic [width_height-1:0]              activein,
   output logic [sum_bits*width_height-1:0]     row_data,
   output logic                                 row_valid,
   input  logic                                 row_ready,
   output logic [cnt_bits(fifo_depth)-1:0]      fifo_count,
   output logic                                 skew_err,
   output logic                                 overflow,
   input  logic                                 clear_err
);
   logic [sum_bits*width_height-1:0] w_al_data;
   logic [width_height-1:0]          w_al_v;
   logic                             w_write;
   logic                             w_skew;
   logic                             w_full;
   logic                             w_empty;
   logic                             w_drop;
   logic                             r_skew;
   logic                             r_ovf;

   // column j needs width_height-j stages so every column lands on the same edge
   for (genvar j = 0; j < width_height; j++) begin : g_col
      localparam int S = width_height - j;
      logic [sum_bits-1:0] r_d [S];
      logic [S-1:0]        r_v;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            for (int k = 0; k < S; k++) r_d[k] <= '0;
            r_v <= '0;
         end else begin
            r_d[0] <= maccin[col_lsb(j, sum_bits) +: sum_bits];
            r_v[0] <= activein[j];
            for (int k = 1; k < S; k++) begin
               r_d[k] <= r_d[k-1];
               r_v[k] <= r_v[k-1];
            end
         end
      end
      assign w_al_data[col_lsb(j, sum_bits) +: sum_bits] = r_d[S-1];
      assign w_al_v[j] = r_v[S-1];
   end

   assign w_write = &w_al_v;
   assign w_skew  = |w_al_v & ~w_write;
   assign w_drop  = w_write & w_full & ~row_ready;

   sys_arr_sync_fifo #(
      .width(sum_bits * width_height),
      .depth(fifo_depth)
   ) u_fifo (
      .clock  (clock),
      .reset_n(reset_n),
      .push   (w_write),
      .pop    (row_ready),
      .din    (w_al_data),
      .dout   (row_data),
      .full   (w_full),
      .empty  (w_empty),
      .count  (fifo_count)
   );

   assign row_valid = ~w_empty;
   assign skew_err  = r_skew;
   assign overflow  = r_ovf;

   // a set event in the same cycle as clear_err keeps the flag set
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_skew <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_skew <= w_skew ? 1'b1 : clear_err ? 1'b0 : r_skew;
         r_ovf  <= w_drop ? 1'b1 : clear_err ? 1'b0 : r_ovf;
      end
   end
endmodule

// File: tb/tb_sys_arr_deskew.sv
// tb_sys_arr_deskew: scenario tasks drive skewed rows; a negedge monitor pops the expected-row queue on each handshake.
module tb_sys_arr_deskew;
   logic        clock;
   logic        reset_n;
   logic [63:0] maccin;
   logic [3:0]  activein;
   logic [63:0] row_data;
   logic        row_valid;
   logic        row_ready;
   logic [2:0]  fifo_count;
   logic        skew_err;
   logic        overflow;
   logic        clear_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] stim [8];

   sys_arr_deskew #(.width_height(4), .fifo_depth(4), .sum_bits(16)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .maccin    (maccin),
      .activein  (activein),
      .row_data  (row_data),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .fifo_count(fifo_count),
      .skew_err  (skew_err),
      .overflow  (overflow),
      .clear_err (clear_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (reset_n === 1'b1 && row_valid === 1'b1 && row_ready === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: row_data=%h, required no row", row_data);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (row_data !== e) begin
               n_fail++;
               $display("FAIL pop_data: row_data=%h, required %h", row_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [63:0] row4(input int k);
      logic [15:0] v;
      v = k[15:0];
      return {v, v, v, v};
   endfunction

   task automatic drive_skew(input int n, input logic [3:0] mask);
      for (int c = 0; c < n + 3; c++) begin
         for (int j = 0; j < 4; j++) begin
            int r;
            r = c - j;
            if (r >= 0 && r < n) begin
               maccin[16*j +: 16] = stim[r][16*j +: 16];
               activein[j]        = mask[j];
            end else begin
               maccin[16*j +: 16] = '0;
               activein[j]        = 1'b0;
            end
         end
         tick();
      end
      maccin   = '0;
      activein = '0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 20 && fifo_count != 0; i++) tick();
      n_tests++;
      if (fifo_count !== 3'd0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: count=%0d left=%0d, required 0 and 0", name, fifo_count, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      maccin    = '0;
      activein  = '0;
      row_ready = 1'b0;
      clear_err = 1'b0;
      #2;
      n_tests++;
      if (row_valid !== 1'b0 || row_data !== 64'h0 || fifo_count !== 3'd0 || skew_err !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h count=%0d skew=%b ovf=%b, required all zero",
                  row_valid, row_data, fifo_count, skew_err, overflow);
      end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_row();
      row_ready = 1'b1;
      stim[0] = 64'h0044_0033_0022_0011;
      exp_q.push_back(stim[0]);
      drive_skew(1, 4'hF);
      chk("single_not_early", 64'(row_valid), 64'd0);
      tick();
      chk("single_valid", 64'(row_valid), 64'd1);
      chk("single_data", row_data, 64'h0044_0033_0022_0011);
      tick();
      chk("single_valid_drop", 64'(row_valid), 64'd0);
      chk("single_q_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic test_back_pressure();
      row_ready = 1'b0;
      for (int k = 1; k <= 6; k++) stim[k-1] = row4(k);
      for (int k = 1; k <= 4; k++) exp_q.push_back(row4(k));
      drive_skew(6, 4'hF);
      tick();
      tick();
      chk("bp_count_sat", 64'(fifo_count), 64'd4);
      chk("bp_overflow", 64'(overflow), 64'd1);
      chk("bp_head", row_data, row4(1));
      row_ready = 1'b1;
      wait_drain("bp_drain");
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("bp_ovf_cleared", 64'(overflow), 64'd0);
   endtask

   task automatic test_full_push_pop();
      row_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         stim[k] = row4(16 + k);
         exp_q.push_back(row4(16 + k));
      end
      drive_skew(5, 4'hF);
      chk("fpp_full_before", 64'(fifo_count), 64'd4);
      row_ready = 1'b1;
      tick();
      chk("fpp_count_held", 64'(fifo_count), 64'd4);
      chk("fpp_no_overflow", 64'(overflow), 64'd0);
      wait_drain("fpp_drain");
   endtask

   task automatic test_skew_err();
      row_ready = 1'b1;
      stim[0] = 64'h0044_0033_0022_0011;
      drive_skew(1, 4'b1011);
      chk("skew_not_early", 64'(skew_err), 64'd0);
      tick();
      chk("skew_set", 64'(skew_err), 64'd1);
      chk("skew_no_write", 64'(fifo_count), 64'd0);
      tick();
      chk("skew_sticky", 64'(skew_err), 64'd1);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("skew_cleared", 64'(skew_err), 64'd0);
   endtask

   task automatic test_async_reset();
      logic bad;
      row_ready = 1'b0;
      stim[0] = row4(7);
      drive_skew(1, 4'b0001);
      for (int k = 0; k < 3; k++) stim[k] = row4(32 + k);
      drive_skew(3, 4'hF);
      chk("ar_pre_count", 64'(fifo_count), 64'd2);
      chk("ar_pre_skew", 64'(skew_err), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      n_tests++;
      if (row_valid !== 1'b0 || fifo_count !== 3'd0 || skew_err !== 1'b0 || overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ar_immediate: valid=%b count=%0d skew=%b ovf=%b, required all zero",
                  row_valid, fifo_count, skew_err, overflow);
      end
      tick();
      reset_n = 1'b1;
      row_ready = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (row_valid !== 1'b0 || fifo_count !== 3'd0 || skew_err !== 1'b0) bad = 1'b1;
      end
      chk("ar_no_ghost_row", 64'(bad), 64'd0);
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_back_pressure();
      test_full_push_pop();
      test_skew_err();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
